// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Shared definitions for the multi-channel two's complement
//               block: the per-channel operation codes, the sequencer state
//               encoding, and a helper that sizes the channel counter.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Per-channel operation codes carried on the mode bus
  localparam logic [1:0] MODE_PASS = 2'b00;  // y = x
  localparam logic [1:0] MODE_NEG  = 2'b01;  // y = ~x + 1
  localparam logic [1:0] MODE_ABS  = 2'b10;  // y = |x|, two's complement
  localparam logic [1:0] MODE_ONES = 2'b11;  // y = ~x

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The channel counter needs at least one bit even for a single channel
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/twos_comp_unit.sv
`default_nettype none
// ============================================================================
// Module      : twos_comp_unit
// Description : Combinational single-channel operator: pass, negate,
//               absolute value or ones complement of a WIDTH-bit operand.
//               Optional macro TWOS_COMP_OVF_EN enables the overflow flag
//               (negate/abs of the most negative value); otherwise the flag
//               is tied low.
// Ports       : x    - operand
//               mode - operation code (see calc_pkg)
//               y    - result
//               ovf  - overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module twos_comp_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH-1:0] neg;
  assign neg = ~x + WIDTH'(1);

  always_comb begin
    y = x;
    case (mode)
      MODE_PASS: y = x;
      MODE_NEG:  y = neg;
      MODE_ABS:  y = x[WIDTH-1] ? neg : x;
      MODE_ONES: y = ~x;
      default:   y = x;
    endcase
  end

`ifdef TWOS_COMP_OVF_EN
  // The most negative value has no positive counterpart, so negating it
  // wraps back to itself.
  logic is_min;
  assign is_min = (x == {1'b1, {(WIDTH-1){1'b0}}});
  assign ovf    = is_min && ((mode == MODE_NEG) || (mode == MODE_ABS));
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_ch_twos_comp.sv
`default_nettype none
// ============================================================================
// Module      : multi_ch_twos_comp
// Description : Sequential multi-channel two's complement converter. A start
//               in IDLE captures din/mode; one channel is processed per clock
//               through a single shared twos_comp_unit; all results are
//               published to dout/ovf together on entry to DONE.
//               Optional macro TWOS_COMP_OVF_EN enables per-channel overflow
//               flags; without it ovf is constant zero.
// Ports       : clk   - clock, rising edge
//               rst   - asynchronous active-high reset
//               start - begin a conversion (sampled in IDLE and DONE)
//               mode  - 2 bits per channel operation codes
//               din   - WIDTH bits per channel operands
//               busy  - conversion in progress
//               done  - one-cycle completion pulse
//               dout  - WIDTH bits per channel results
//               ovf   - per-channel overflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module multi_ch_twos_comp
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*NCH-1:0]     mode,
  input  logic [WIDTH*NCH-1:0] din,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH*NCH-1:0] dout,
  output logic [NCH-1:0]       ovf
);

  localparam int            CW   = cnt_width(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WIDTH*NCH-1:0]   cap_din;
  logic [2*NCH-1:0]       cap_mode;
  logic [WIDTH*NCH-1:0]   res;
  logic [WIDTH*NCH-1:0]   res_next;

  logic [WIDTH-1:0]       unit_x;
  logic [1:0]             unit_mode;
  logic [WIDTH-1:0]       unit_y;
  logic                   unit_ovf;

  // Route the channel selected by the counter into the shared unit
  always_comb begin
    unit_x    = '0;
    unit_mode = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt == CW'(k)) begin
        unit_x    = cap_din[k*WIDTH +: WIDTH];
        unit_mode = cap_mode[2*k +: 2];
      end
    end
  end

  twos_comp_unit #(
    .WIDTH (WIDTH)
  ) u_unit (
    .x    (unit_x),
    .mode (unit_mode),
    .y    (unit_y),
    .ovf  (unit_ovf)
  );

  // Result vector with the current channel's slot replaced; on the last
  // channel this is the complete set that gets published in one step.
  always_comb begin
    res_next = res;
    for (int k = 0; k < NCH; k++) begin
      if (cnt == CW'(k)) res_next[k*WIDTH +: WIDTH] = unit_y;
    end
  end

`ifdef TWOS_COMP_OVF_EN
  logic [NCH-1:0] res_ovf;
  logic [NCH-1:0] res_ovf_next;

  always_comb begin
    res_ovf_next = res_ovf;
    for (int k = 0; k < NCH; k++) begin
      if (cnt == CW'(k)) res_ovf_next[k] = unit_ovf;
    end
  end
`else
  // The unit's flag is constant zero in this build
  assign ovf = {NCH{unit_ovf}};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      cap_din  <= '0;
      cap_mode <= '0;
      res      <= '0;
`ifdef TWOS_COMP_OVF_EN
      ovf      <= '0;
      res_ovf  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cap_din  <= din;
            cap_mode <= mode;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          res <= res_next;
`ifdef TWOS_COMP_OVF_EN
          res_ovf <= res_ovf_next;
`endif
          if (cnt == LAST) begin
            dout  <= res_next;
`ifdef TWOS_COMP_OVF_EN
            ovf   <= res_ovf_next;
`endif
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back conversion without passing through IDLE
            cap_din  <= din;
            cap_mode <= mode;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_ch_twos_comp.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_ch_twos_comp
// Description : Self-checking bench for multi_ch_twos_comp (WIDTH=4, NCH=2).
//               A behavioural model predicts busy/done/dout/ovf every cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_ch_twos_comp;

  localparam int WIDTH = 4;
  localparam int NCH   = 2;
  localparam int DW    = WIDTH * NCH;

`ifdef TWOS_COMP_OVF_EN
  localparam logic [NCH-1:0] OVF_MIN = 2'b11;
`else
  localparam logic [NCH-1:0] OVF_MIN = 2'b00;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*NCH-1:0] mode;
  logic [DW-1:0]   din;
  logic            busy;
  logic            done;
  logic [DW-1:0]   dout;
  logic [NCH-1:0]  ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_ch_twos_comp #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-channel arithmetic straight from the operation definitions
  function automatic int op_y(input int x, input int m);
    int full = 1 << WIDTH;
    int half = full / 2;
    case (m)
      0:       return x;
      1:       return (full - x) % full;
      2:       return (x >= half) ? (full - x) % full : x;
      default: return full - 1 - x;
    endcase
  endfunction

  function automatic bit op_ovf(input int x, input int m);
`ifdef TWOS_COMP_OVF_EN
    return ((m == 1) || (m == 2)) && (x == (1 << (WIDTH - 1)));
`else
    return (x < 0) && (m < 0);
`endif
  endfunction

  logic            m_busy, m_done;
  logic [DW-1:0]   m_dout, pend_dout;
  logic [NCH-1:0]  m_ovf, pend_ovf;
  int              left;   // edges remaining until results publish

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dout = '0; m_ovf = '0; left = 0;
    end else if (left > 0) begin
      m_done = 1'b0;
      left--;
      if (left == 0) begin
        m_dout = pend_dout; m_ovf = pend_ovf; m_done = 1'b1; m_busy = 1'b0;
      end
    end else begin
      m_done = 1'b0;
      m_busy = 1'b0;
      if (start) begin
        for (int k = 0; k < NCH; k++) begin
          pend_dout[k*WIDTH +: WIDTH] = WIDTH'(op_y(int'(din[k*WIDTH +: WIDTH]), int'(mode[2*k +: 2])));
          pend_ovf[k] = op_ovf(int'(din[k*WIDTH +: WIDTH]), int'(mode[2*k +: 2]));
        end
        left   = NCH;
        m_busy = 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("dout", 32'(dout), 32'(m_dout));
    check("ovf",  32'(ovf),  32'(m_ovf));
  end

  // ---------------- directed stimulus ----------------
  task automatic run_conv(input string name, input logic [DW-1:0] d, input logic [2*NCH-1:0] m,
                          input logic [DW-1:0] exp_dout, input logic [NCH-1:0] exp_ovf);
    int n;
    @(negedge clk); din = d; mode = m; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 1;
    while (!done && n < 10) begin
      @(negedge clk); n++;
    end
    check({name, "_latency"}, 32'(n), 32'(NCH + 1));
    check({name, "_dout"}, 32'(dout), 32'(exp_dout));
    check({name, "_ovf"},  32'(ovf),  32'(exp_ovf));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int pulses, t, first, second;
    rst = 1'b1; start = 1'b0; din = '0; mode = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    #2 rst = 1'b0;

    // negate / pass
    run_conv("neg_pass", 8'h53, 4'b0001, 8'h5D, 2'b00);
    // abs of negative / ones complement
    run_conv("abs_ones", 8'h6A, 4'b1110, 8'h96, 2'b00);
    // most negative value under negate and abs
    run_conv("minval",   8'h88, 4'b1001, 8'h88, OVF_MIN);
    // abs of positive passes, ones complement of zero
    run_conv("abs_pos",  8'h05, 4'b1110, 8'hF5, 2'b00);

    // start re-asserted during RUN with different operands is ignored
    @(negedge clk); din = 8'h53; mode = 4'b0001; start = 1'b1;
    pulses = 0;
    @(negedge clk); din = 8'hFF; mode = 4'b1111; start = 1'b1;
    if (done) pulses++;
    @(negedge clk); start = 1'b0;
    if (done) pulses++;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_dout",   32'(dout),   32'h5D);

    // reset on the edge after start aborts the conversion
    @(negedge clk); din = 8'h3A; mode = 4'b0110; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #2 rst = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dout", 32'(dout), 32'd0);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    run_conv("after_rst", 8'h53, 4'b0001, 8'h5D, 2'b00);

    // start held through DONE: back-to-back conversions
    @(negedge clk); din = 8'h3A; mode = 4'b0110; start = 1'b1;
    t = 0; first = -1; second = -1;
    for (int i = 0; i < 20 && second < 0; i++) begin
      @(negedge clk); t++;
      if (done) begin
        if (first < 0) first = t;
        else second = t;
      end
    end
    start = 1'b0;
    check("b2b_gap",  32'(second - first), 32'(NCH + 1));
    check("b2b_dout", 32'(dout), 32'hD6);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_ch_twos_comp.md
MULTI_CH_TWOS_COMP -- requirements
Module: multi_ch_twos_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits per channel (legal WIDTH >= 2).
REQ-002 SHALL have parameter NCH, default 2, number of operand channels (legal NCH >= 1).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a conversion.
REQ-006 SHALL have port mode  input  2*NCH  per-channel operation; channel k uses bits [2k+1:2k].
REQ-007 SHALL have port din  input  WIDTH*NCH  operands; channel k uses bits [WIDTH*k+WIDTH-1:WIDTH*k].
REQ-008 SHALL have port busy  output  1  high while a conversion is running.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port dout  output  WIDTH*NCH  results, same channel packing as din.
REQ-011 SHALL have port ovf  output  NCH  per-channel overflow flag.

Function
REQ-012 SHALL decode mode as: 00 pass (x), 01 negate (~x+1 mod 2^WIDTH), 10 absolute value (negate if MSB=1, else pass), 11 ones complement (~x).
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; the reset state is IDLE.
REQ-014 In IDLE, start=1 at edge T SHALL capture din and mode into internal registers, clear the channel counter, and enter RUN; busy SHALL be 1 from T.
REQ-015 In RUN, each edge SHALL compute the channel indexed by the counter into an internal result register and increment the counter; channels are processed in order 0..NCH-1, one per edge (edges T+1..T+NCH).
REQ-016 On the edge that processes channel NCH-1, the FSM SHALL enter DONE and load all results into dout and ovf atomically; dout and ovf SHALL never show a partial update.
REQ-017 In DONE, done=1 and busy=0 for exactly one cycle; the next edge SHALL go to RUN if start=1 (back-to-back capture, as in REQ-014), otherwise to IDLE.
REQ-018 start in RUN SHALL be ignored, and changes to din/mode after capture SHALL not affect the running conversion.
REQ-019 dout and ovf SHALL hold their last values until the next DONE entry.
REQ-020 The channel counter width SHALL be max(1, clog2(NCH)) and SHALL never exceed NCH-1.

Reset
REQ-021 rst=1 SHALL force, asynchronously: state IDLE, counter 0, busy 0, done 0, dout all 0, ovf all 0, and all capture and result registers 0.
REQ-022 rst asserted mid-RUN SHALL abort the conversion with no done pulse; after release, the block SHALL accept a new start normally.

Configuration
REQ-023 Macro TWOS_COMP_OVF_EN defined: ovf[k]=1 when channel k has mode 01 or 10 and its operand is the most negative value (1 followed by WIDTH-1 zeros); otherwise 0.
REQ-024 Macro TWOS_COMP_OVF_EN undefined: the ovf port SHALL still exist, tied to all 0, with no overflow logic synthesised.

Structure
REQ-025 Shared package calc_pkg SHALL hold the mode encoding constants (MODE_PASS, MODE_NEG, MODE_ABS, MODE_ONES) and the FSM state encoding.
REQ-026 A combinational sub-module twos_comp_unit (WIDTH-parametrised; inputs x, mode; outputs y, ovf) SHALL perform the single-channel operation and be instantiated once, multiplexed by the channel counter.

Verification (WIDTH=4, NCH=2, TWOS_COMP_OVF_EN defined unless noted)
REQ-027 din ch0=0011 mode 01, ch1=0101 mode 00; pulse start -> done exactly 3 cycles after the start edge; dout ch0=1101, ch1=0101; ovf=00.
REQ-028 ch0=1010 mode 10, ch1=0110 mode 11 -> dout ch0=0110, ch1=1001; ovf=00.
REQ-029 ch0=1000 mode 01, ch1=1000 mode 10 -> dout ch0=1000, ch1=1000; ovf=11; same stimulus with macro undefined -> ovf=00.
REQ-030 start re-asserted during RUN with different din -> ignored; results match the first capture; exactly one done pulse.
REQ-031 rst asserted on the edge after start -> busy=0, dout=0, no done pulse; a subsequent start completes correctly.
REQ-032 start held high through DONE -> second conversion begins directly; done pulses are separated by NCH+1 cycles.
